// File: rtl/seg7_scan_if.sv
// Bus bundle between a value-register master and the 7-segment scan controller.
interface seg7_scan_if #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned SEL_W  = 3
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [SEL_W-1:0]      sel;
  logic [7:0]            seg;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output load, data_in, dp_in, blank_in,
    input  sel, seg, pending, frame_done
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    output sel, seg, pending, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner with shadow/display registers committed at frame boundaries.
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS     = 6,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned SEG_ACT_LO = 1
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int unsigned PresW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0]  Dark  = (SEG_ACT_LO != 0) ? 8'hFF : 8'h00;

  logic [PresW-1:0]    presc_q, presc_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_data_q, shd_data_d, disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   shd_blank_q, shd_blank_d, disp_blank_q, disp_blank_d;
  logic                pending_q, pending_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          seg_q, seg_d;
  logic                tick, boundary;
  logic [4*DIGITS-1:0] data_sh;
  logic [DIGITS-1:0]   dp_sh, blank_sh;
  logic [7:0]          raw;
  int unsigned         pos;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]   lz_q, lz_d, lz_sh;
`endif

  // Active-low a..g pattern, bit 0 = a.
  function automatic logic [6:0] font(input logic [3:0] n);
    logic [6:0] f;
    case (n)
      4'h0: f = 7'h40;  4'h1: f = 7'h79;  4'h2: f = 7'h24;  4'h3: f = 7'h30;
      4'h4: f = 7'h19;  4'h5: f = 7'h12;  4'h6: f = 7'h02;  4'h7: f = 7'h78;
      4'h8: f = 7'h00;  4'h9: f = 7'h10;  4'hA: f = 7'h08;  4'hB: f = 7'h03;
      4'hC: f = 7'h46;  4'hD: f = 7'h21;  4'hE: f = 7'h06;  default: f = 7'h0E;
    endcase
    return f;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Bit DIGITS-1 = digit 0; the last digit is never suppressed.
  function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] d);
    logic [DIGITS-1:0]   m;
    logic [4*DIGITS-1:0] sh;
    logic                run;
    m   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      sh  = d << (4 * i);
      run = run && (sh[4*DIGITS-1 -: 4] == 4'h0);
      m   = {m[DIGITS-2:0], run};
    end
    return {m[DIGITS-2:0], 1'b0};
  endfunction
`endif

  always_comb begin
    tick     = (presc_q == PresW'(CLK_DIV - 1));
    boundary = tick && (idx_q == SEL_W'(DIGITS - 1));
    presc_d  = tick ? '0 : presc_q + 1'b1;
    idx_d    = idx_q;
    if (tick) idx_d = boundary ? '0 : idx_q + 1'b1;

    shd_data_d   = shd_data_q;
    shd_dp_d     = shd_dp_q;
    shd_blank_d  = shd_blank_q;
    disp_data_d  = disp_data_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;
    pending_d    = pending_q;
    frame_done_d = boundary;
`ifdef LEADING_ZERO_BLANK_EN
    lz_d         = lz_q;
`endif

    // A load landing on the boundary bypasses the shadow entirely.
    if (bus.load && boundary) begin
      disp_data_d  = bus.data_in;
      disp_dp_d    = bus.dp_in;
      disp_blank_d = bus.blank_in;
      pending_d    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lz_d         = lz_mask(bus.data_in);
`endif
    end else if (bus.load) begin
      shd_data_d  = bus.data_in;
      shd_dp_d    = bus.dp_in;
      shd_blank_d = bus.blank_in;
      pending_d   = 1'b1;
    end else if (boundary && pending_q) begin
      disp_data_d  = shd_data_q;
      disp_dp_d    = shd_dp_q;
      disp_blank_d = shd_blank_q;
      pending_d    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      lz_d         = lz_mask(shd_data_q);
`endif
    end

    // seg is decoded from next-state idx/display so it lands on the same edge as sel.
    pos      = DIGITS - 1 - 32'(idx_d);
    data_sh  = disp_data_d >> (4 * pos);
    dp_sh    = disp_dp_d >> pos;
    blank_sh = disp_blank_d >> pos;
    raw      = {~dp_sh[0], font(data_sh[3:0])};
`ifdef LEADING_ZERO_BLANK_EN
    lz_sh    = lz_d >> pos;
    if (lz_sh[0]) raw = {~dp_sh[0], 7'h7F};
`endif
    if (blank_sh[0]) raw = 8'hFF;
    seg_d = (SEG_ACT_LO != 0) ? raw : ~raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shd_data_q   <= '0;
      shd_dp_q     <= '0;
      shd_blank_q  <= '0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= Dark;
`ifdef LEADING_ZERO_BLANK_EN
      lz_q         <= '0;
`endif
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shd_data_q   <= shd_data_d;
      shd_dp_q     <= shd_dp_d;
      shd_blank_q  <= shd_blank_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      pending_q    <= pending_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
`ifdef LEADING_ZERO_BLANK_EN
      lz_q         <= lz_d;
`endif
    end
  end

  assign bus.sel        = idx_q;
  assign bus.seg        = seg_q;
  assign bus.pending    = pending_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: vector table, corner sequences and a random run against a cycle model.
`timescale 1ns/1ps
module tb_seg7_scan_ctrl;
  localparam int unsigned DIGITS  = 6;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned FRAME   = DIGITS * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.DIGITS(DIGITS), .SEL_W(SEL_W)) bus ();

  seg7_scan_ctrl #(
    .DIGITS    (DIGITS),
    .SEL_W     (SEL_W),
    .CLK_DIV   (CLK_DIV),
    .SEG_ACT_LO(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [23:0]     data;
    logic [5:0]      dp;
    logic [5:0]      blank;
    logic [0:5][7:0] seg;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int k;  // edges since reset released; slot and frame position follow from it
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int m_nib [DIGITS], m_dp [DIGITS], m_bl [DIGITS];
  int s_nib [DIGITS], s_dp [DIGITS], s_bl [DIGITS];
  int m_pend, m_fd;

  function automatic logic [7:0] exp_seg(int d);
    logic [7:0] v;
`ifdef LEADING_ZERO_BLANK_EN
    bit sup;
`endif
    if (m_bl[d] != 0) return 8'hFF;
    v = font[m_nib[d]];
`ifdef LEADING_ZERO_BLANK_EN
    sup = (d < DIGITS - 1);
    for (int j = 0; j <= d; j++) if (m_nib[j] != 0) sup = 0;
    if (sup) v = 8'hFF;
`endif
    if (m_dp[d] != 0) v[7] = 1'b0;
    return v;
  endfunction

  task automatic model_edge();
    bit bnd;
    if (rst) begin
      k = 0;
      for (int d = 0; d < DIGITS; d++) begin
        m_nib[d] = 0; m_dp[d] = 0; m_bl[d] = 1;
        s_nib[d] = 0; s_dp[d] = 0; s_bl[d] = 0;
      end
      m_pend = 0;
      m_fd   = 0;
    end else begin
      k++;
      bnd  = (k % FRAME) == 0;
      m_fd = bnd ? 1 : 0;
      if (bus.load) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (bnd) begin
            m_nib[d] = int'((bus.data_in >> (4 * (DIGITS - 1 - d))) & 24'hF);
            m_dp[d]  = int'(bus.dp_in[DIGITS-1-d]);
            m_bl[d]  = int'(bus.blank_in[DIGITS-1-d]);
          end else begin
            s_nib[d] = int'((bus.data_in >> (4 * (DIGITS - 1 - d))) & 24'hF);
            s_dp[d]  = int'(bus.dp_in[DIGITS-1-d]);
            s_bl[d]  = int'(bus.blank_in[DIGITS-1-d]);
          end
        end
        m_pend = bnd ? 0 : 1;
      end else if (bnd && m_pend != 0) begin
        m_nib  = s_nib;
        m_dp   = s_dp;
        m_bl   = s_bl;
        m_pend = 0;
      end
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int cur;
    @(posedge clk);
    model_edge();
    #1;
    cur = (k / CLK_DIV) % DIGITS;
    check("sel", 32'(bus.sel), cur);
    check("seg", 32'(bus.seg), 32'(exp_seg(cur)));
    check("pending", 32'(bus.pending), m_pend);
    check("frame_done", 32'(bus.frame_done), m_fd);
  endtask

  task automatic do_load(logic [23:0] d, logic [5:0] dp, logic [5:0] bl);
    bus.data_in  = d;
    bus.dp_in    = dp;
    bus.blank_in = bl;
    bus.load     = 1'b1;
    step();
    bus.load     = 1'b0;
  endtask

  task automatic run_to_phase(int ph);
    for (int i = 0; i < FRAME && (k % FRAME) != ph; i++) step();
  endtask

  vec_t vec [8];
  int   n_vec;
  int   cnt;

  initial begin
    bus.load = 1'b0; bus.data_in = '0; bus.dp_in = '0; bus.blank_in = '0;
    vec[0] = '{24'h012345, 6'b0, 6'b0, {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92}};
    vec[1] = '{24'hABCDEF, 6'b0, 6'b0, {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E}};
    vec[2] = '{24'h999999, 6'b0, 6'b0, {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90}};
    vec[3] = '{24'h012345, 6'b000001, 6'b100000,
               {8'hFF, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h12}};
    vec[4] = '{24'h678900, 6'b111111, 6'b0, {8'h02, 8'h78, 8'h00, 8'h10, 8'h40, 8'h40}};
    n_vec  = 5;
`ifdef LEADING_ZERO_BLANK_EN
    vec[0].seg[0] = 8'hFF;
    vec[5] = '{24'h000450, 6'b0, 6'b0, {8'hFF, 8'hFF, 8'hFF, 8'h99, 8'h92, 8'hC0}};
    vec[6] = '{24'h000000, 6'b0, 6'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0}};
    n_vec  = 7;
`endif

    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    for (int v = 0; v < n_vec; v++) begin
      do_load(vec[v].data, vec[v].dp, vec[v].blank);
      run_to_phase(0);
      for (int d = 0; d < DIGITS; d++) begin
        check("tab_sel", 32'(bus.sel), d);
        check("tab_seg", 32'(bus.seg), 32'(vec[v].seg[d]));
        repeat (CLK_DIV) step();
      end
    end

    // Two loads in one frame: only the latest reaches the display.
    run_to_phase(10);
    do_load(24'h111111, 6'b0, 6'b0);
    check("two_load_pend", 32'(bus.pending), 1);
    repeat (3) step();
    do_load(24'hABCDEF, 6'b0, 6'b0);
    run_to_phase(0);
    check("two_load_first", 32'(bus.seg), 32'h88);
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      step();
      if (bus.seg == 8'hF9) cnt++;
    end
    check("two_load_stale", cnt, 0);

    // Load on the boundary edge goes straight to display.
    run_to_phase(FRAME - 1);
    bus.data_in = 24'h999999; bus.dp_in = '0; bus.blank_in = '0; bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    check("bnd_load_sel", 32'(bus.sel), 0);
    check("bnd_load_seg", 32'(bus.seg), 32'h90);
    check("bnd_load_pend", 32'(bus.pending), 0);
    cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.frame_done) cnt++;
    end
    check("frame_done_count", cnt, 2);

    // Reset mid-frame with a pending load outstanding.
    run_to_phase(11);
    do_load(24'h123456, 6'b0, 6'b0);
    check("rst_pre_sel", 32'(bus.sel), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_sel", 32'(bus.sel), 0);
    check("rst_seg", 32'(bus.seg), 32'hFF);
    check("rst_pend", 32'(bus.pending), 0);
    cnt = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step();
      if (bus.seg != 8'hFF) cnt++;
    end
    check("rst_dark", cnt, 0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      rst          = ($urandom_range(0, 299) == 0);
      bus.load     = ($urandom_range(0, 7) == 0);
      bus.data_in  = 24'($urandom);
      bus.dp_in    = 6'($urandom);
      bus.blank_in = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'b0;
      step();
    end
    rst = 1'b0;
    bus.load = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
